// File: rtl/pgs_pciex4_dma_pkg.sv
// Shared types and helpers for the PCIe x4 DMA staging FIFO write side.
// Holds the arbiter state encoding, the usable-depth rule and the burst length clamp.
package pgs_pciex4_dma_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int FIFO_ADDR_WIDTH = 9;

    // The FIFO raises full one word short of 2^aw, so that word is never usable.
    function automatic int unsigned fifo_usable_depth(input int unsigned aw);
        return (32'd1 << aw) - 32'd1;
    endfunction

    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned burst_max);
        return (len > burst_max) ? burst_max : len;
    endfunction

endpackage

// File: rtl/pgs_pciex4_rr_pick.sv
// Combinational round-robin search: first eligible requester at or after ptr,
// wrapping modulo NUM_REQ. Returns a one-hot, its index and a found flag.
module pgs_pciex4_rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDXW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] elig,
    input  logic [IDXW-1:0]    ptr,
    output logic               found,
    output logic [IDXW-1:0]    idx,
    output logic [NUM_REQ-1:0] onehot
);

    int              jj;
    logic [IDXW-1:0] j;

    always_comb begin
        found  = 1'b0;
        idx    = '0;
        onehot = '0;
        jj     = 0;
        j      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            jj = (int'(ptr) + k) % NUM_REQ;
            j  = IDXW'(jj);
            if (!found && elig[j]) begin
                found     = 1'b1;
                idx       = j;
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pgs_pciex4_fifo_wr_arb.sv
// Round-robin arbiter sharing the staging FIFO write port between DMA channels.
// A burst is granted only when the FIFO has room for all of it, so it never stalls.
module pgs_pciex4_fifo_wr_arb
    import pgs_pciex4_dma_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int DATA_WIDTH = 128,
    parameter int BURST_MAX  = 16,
    parameter int BLEN_WIDTH = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ*BLEN_WIDTH-1:0]    req_len,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [NUM_REQ-1:0]               data_ack,
    output logic                             fifo_w_en,
    output logic [DATA_WIDTH-1:0]            fifo_wdata,
    input  logic                             fifo_r_en,
    input  logic                             fifo_wfull,
    output logic [ADDR_WIDTH:0]              fifo_free,
    output logic                             err
);

    localparam int IDXW = $clog2(NUM_REQ);
    localparam int OW   = ADDR_WIDTH + 1;
    localparam logic [OW-1:0] DEPTH = OW'(fifo_usable_depth(ADDR_WIDTH));

    arb_state_t            state;
    logic [IDXW-1:0]       rr_ptr, owner, cand_idx;
    logic [BLEN_WIDTH-1:0] beat_cnt, cand_len;
    logic [OW-1:0]         occ, occ_nxt;
    logic [NUM_REQ-1:0]    elig, cand_onehot;
    logic                  cand_found, burst_go, rd_ok, rd_empty;
    logic [BLEN_WIDTH-1:0] lens [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_len
        assign lens[i] = req_len[i*BLEN_WIDTH +: BLEN_WIDTH];
        assign elig[i] = req[i] && (lens[i] != '0);
    end

    pgs_pciex4_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .elig   (elig),
        .ptr    (rr_ptr),
        .found  (cand_found),
        .idx    (cand_idx),
        .onehot (cand_onehot)
    );

    // Only the round-robin candidate is considered; a later requester never jumps it.
    assign cand_len = BLEN_WIDTH'(clamp_len(32'(lens[cand_idx]), BURST_MAX));
    assign burst_go = cand_found && (OW'(cand_len) <= fifo_free);

    assign fifo_w_en  = (state == BURST) && !fifo_wfull;
    assign data_ack   = fifo_w_en ? gnt : '0;
    assign fifo_wdata = (state == BURST) ? req_data[owner*DATA_WIDTH +: DATA_WIDTH] : '0;

    assign rd_ok    = fifo_r_en && (occ != '0);
    assign rd_empty = fifo_r_en && (occ == '0);
    assign occ_nxt  = occ + OW'(fifo_w_en) - OW'(rd_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            beat_cnt  <= '0;
            gnt       <= '0;
            occ       <= '0;
            fifo_free <= DEPTH;
            err       <= 1'b0;
        end else begin
            occ       <= occ_nxt;
            fifo_free <= DEPTH - occ_nxt;
            if (rd_empty || (state == BURST && fifo_wfull))
                err <= 1'b1;
            case (state)
                IDLE: begin
                    if (burst_go) begin
                        owner    <= cand_idx;
                        beat_cnt <= cand_len;
                        gnt      <= cand_onehot;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (!fifo_wfull) begin
                        beat_cnt <= beat_cnt - 1'b1;
                        if (beat_cnt == BLEN_WIDTH'(1)) begin
                            state  <= IDLE;
                            gnt    <= '0;
                            rr_ptr <= (owner == IDXW'(NUM_REQ-1)) ? '0 : owner + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pgs_pciex4_fifo_wr_arb.sv
// Self-checking bench for pgs_pciex4_fifo_wr_arb: directed scenarios plus random traffic,
// every cycle compared against a transaction-level model of the arbitration rules.
module tb_pgs_pciex4_fifo_wr_arb;

    localparam int N     = 4;
    localparam int AW    = 9;
    localparam int DW    = 128;
    localparam int BM    = 16;
    localparam int BW    = 5;
    localparam int DEPTH = 511;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*BW-1:0] req_len = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    gnt, data_ack;
    logic            fifo_w_en;
    logic [DW-1:0]   fifo_wdata;
    logic            fifo_r_en = 1'b0;
    logic            fifo_wfull = 1'b0;
    logic [AW:0]     fifo_free;
    logic            err;

    pgs_pciex4_fifo_wr_arb #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_MAX(BM), .BLEN_WIDTH(BW)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_len(req_len), .req_data(req_data),
        .gnt(gnt), .data_ack(data_ack), .fifo_w_en(fifo_w_en), .fifo_wdata(fifo_wdata),
        .fifo_r_en(fifo_r_en), .fifo_wfull(fifo_wfull), .fifo_free(fifo_free), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: one outstanding burst (owner, beats left), a round-robin
    // pointer, FIFO word count and the sticky error.
    bit           m_busy  = 0;
    int           m_owner = 0;
    int           m_left  = 0;
    int           m_ptr   = 0;
    int           m_occ   = 0;
    bit           m_err   = 0;
    int           wen_cnt = 0;
    int           glog[$];
    logic [N-1:0] prev_gnt = '0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge with inputs for the coming rising edge already applied.
    task automatic cycle();
        bit            ew;
        int            occ0, first, len;
        logic [DW-1:0] exp_wd;
        for (int i = 0; i < N; i++)
            req_data[i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
        #1;
        occ0   = m_occ;
        ew     = m_busy && !fifo_wfull;
        exp_wd = m_busy ? req_data[m_owner*DW +: DW] : '0;
        check_val("gnt",   gnt,        m_busy ? (128'd1 << m_owner) : 128'd0);
        check_val("w_en",  fifo_w_en,  ew);
        check_val("ack",   data_ack,   ew ? (128'd1 << m_owner) : 128'd0);
        check_val("wdata", fifo_wdata, exp_wd);
        check_val("free",  fifo_free,  DEPTH - m_occ);
        check_val("err",   err,        m_err);
        if (fifo_w_en) wen_cnt++;
        if (gnt != 0 && prev_gnt == 0)
            for (int i = 0; i < N; i++) if (gnt[i]) glog.push_back(i);
        prev_gnt = gnt;

        if (fifo_r_en && m_occ == 0) m_err = 1;
        else if (fifo_r_en) m_occ--;
        if (ew) m_occ++;
        if (m_busy) begin
            if (fifo_wfull) m_err = 1;
            else begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0;
                    m_ptr  = (m_owner + 1) % N;
                end
            end
        end else begin
            first = -1;
            for (int k = 0; k < N && first < 0; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (req[i] && req_len[i*BW +: BW] != 0) first = i;
            end
            if (first >= 0) begin
                len = int'(req_len[first*BW +: BW]);
                if (len > BM) len = BM;
                if (len <= DEPTH - occ0) begin
                    m_busy  = 1;
                    m_owner = first;
                    m_left  = len;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0; req_len = '0; fifo_r_en = 1'b0; fifo_wfull = 1'b0;
        #1;
        check_val("rst_gnt",   gnt,        0);
        check_val("rst_w_en",  fifo_w_en,  0);
        check_val("rst_ack",   data_ack,   0);
        check_val("rst_wdata", fifo_wdata, 0);
        check_val("rst_free",  fifo_free,  DEPTH);
        check_val("rst_err",   err,        0);
        m_busy = 0; m_ptr = 0; m_occ = 0; m_err = 0; m_left = 0; prev_gnt = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fill_to(input int target);
        req = 4'b0001;
        req_len[BW-1:0] = 5'd16;
        for (int g = 0; g < 1200 && m_occ < (target / 16) * 16; g++) cycle();
        req_len[BW-1:0] = 5'(target % 16);
        for (int g = 0; g < 100 && m_occ < target; g++) cycle();
        req = '0; req_len = '0;
        check_val("fill_free", fifo_free, DEPTH - target);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1);
    end

    initial begin
        int rd_pct;
        @(negedge clk);

        // Single burst of 4 into an empty FIFO.
        do_reset();
        req = 4'b0001; req_len[BW-1:0] = 5'd4; wen_cnt = 0;
        cycle();
        req = '0; req_len = '0;
        check_val("t1_gnt_n1", gnt, 4'b0001);
        repeat (6) cycle();
        check_val("t1_beats", wen_cnt, 4);
        check_val("t1_free", fifo_free, 507);
        check_val("t1_idle", gnt, 0);

        // Four requesters, length 2 each: rotation 0,1,2,3,0.
        do_reset();
        req = 4'hF; req_len = {4{5'd2}}; glog.delete();
        repeat (15) cycle();
        req = '0; req_len = '0;
        check_val("t2_nbursts", glog.size(), 5);
        for (int k = 0; k < glog.size() && k < 5; k++) check_val("t2_order", glog[k], k % N);
        check_val("t2_free", fifo_free, DEPTH - 10);
        repeat (4) cycle();

        // Head-of-line wait at occupancy 500: requester 1 blocks requester 2.
        do_reset();
        fill_to(500);
        req = 4'b0110; req_len[BW +: BW] = 5'd16; req_len[2*BW +: BW] = 5'd2; glog.delete();
        repeat (6) cycle();
        check_val("t3_noskip_gnt", gnt, 0);
        check_val("t3_noskip_log", glog.size(), 0);
        fifo_r_en = 1'b1;
        repeat (5) cycle();
        fifo_r_en = 1'b0;
        check_val("t3_free16", fifo_free, 16);
        cycle();
        check_val("t3_gnt1", gnt, 4'b0010);
        req = '0; req_len = '0;
        repeat (18) cycle();

        // Read on every beat of an 8-beat burst at occupancy 100, then underflow read.
        do_reset();
        fill_to(100);
        req = 4'b0001; req_len[BW-1:0] = 5'd8;
        cycle();
        req = '0; req_len = '0;
        for (int k = 0; k < 10; k++) begin
            fifo_r_en = m_busy;
            cycle();
        end
        fifo_r_en = 1'b0;
        check_val("t4_occ_hold", fifo_free, DEPTH - 100);
        for (int g = 0; g < 200 && m_occ > 0; g++) begin
            fifo_r_en = 1'b1;
            cycle();
        end
        fifo_r_en = 1'b0;
        check_val("t4_err_pre", err, 0);
        fifo_r_en = 1'b1;
        cycle();
        fifo_r_en = 1'b0;
        check_val("t4_err_underflow", err, 1);
        check_val("t4_free_empty", fifo_free, DEPTH);

        // Zero length is never granted; 31 is clamped to 16.
        do_reset();
        req = 4'b0011; req_len[BW-1:0] = 5'd0; req_len[BW +: BW] = 5'd31;
        glog.delete(); wen_cnt = 0;
        repeat (18) cycle();
        check_val("t5_beats", wen_cnt, 16);
        repeat (20) cycle();
        req = '0; req_len = '0;
        check_val("t5_nbursts", glog.size() >= 2, 1);
        for (int k = 0; k < glog.size(); k++) check_val("t5_owner", glog[k], 1);
        repeat (20) cycle();

        // Reset on the third beat of a 10-beat burst.
        do_reset();
        req = 4'b0001; req_len[BW-1:0] = 5'd10;
        cycle();
        req = '0; req_len = '0;
        cycle(); cycle();
        #1;
        check_val("t6_mid_wen", fifo_w_en, 1);
        do_reset();
        req = 4'b0011; req_len[BW-1:0] = 5'd1; req_len[BW +: BW] = 5'd1; glog.delete();
        repeat (6) cycle();
        req = '0; req_len = '0;
        check_val("t6_ptr0", glog.size() > 0 ? glog[0] : -1, 0);
        repeat (3) cycle();

        // Full flag mid-burst holds the beat and flags an error.
        do_reset();
        req = 4'b0001; req_len[BW-1:0] = 5'd6;
        cycle();
        req = '0; req_len = '0; wen_cnt = 0;
        cycle(); cycle();
        fifo_wfull = 1'b1;
        #1;
        check_val("t7_wfull_wen", fifo_w_en, 0);
        check_val("t7_wfull_ack", data_ack, 0);
        cycle();
        fifo_wfull = 1'b0;
        check_val("t7_err", err, 1);
        repeat (8) cycle();
        check_val("t7_beats", wen_cnt, 6);
        check_val("t7_free", fifo_free, DEPTH - 6);

        // Random traffic against the model.
        do_reset();
        rd_pct = 30;
        for (int c = 0; c < 2500; c++) begin
            if (c % 400 == 0) rd_pct = $urandom_range(5, 90);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            if ($urandom_range(0, 7) == 0)
                for (int i = 0; i < N; i++) req_len[i*BW +: BW] = 5'($urandom_range(0, 20));
            fifo_r_en = (m_occ > 0) && ($urandom_range(0, 99) < rd_pct);
            cycle();
        end
        req = '0; fifo_r_en = 1'b0;
        repeat (20) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
